// File: rtl/ltc2308_pkg.sv
// Shared types and sizes for the LTC2308 serial ADC controller.
package ltc2308_pkg;

  localparam int CFG_W  = 6;
  localparam int DATA_W = 12;
  localparam int NBITS  = 12;
  localparam int BIT_W  = $clog2(NBITS);

  typedef enum logic [2:0] {
    IDLE,
    CONVST,
    WAIT_CONV,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/ltc2308_sck_gen.sv
// SCK generator: NBITS pulses, each SCK_HALF clocks low then SCK_HALF clocks high.
// rise/fall flag the clk cycle whose closing edge moves SCK up/down.
module ltc2308_sck_gen
  import ltc2308_pkg::*;
#(
  parameter int SCK_HALF = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             sck,
  output logic             rise,
  output logic             fall,
  output logic [BIT_W-1:0] bit_idx
);

  localparam int HALF_W = $clog2(SCK_HALF + 1);

  logic [HALF_W-1:0] half_cnt;
  logic              half_end;

  assign half_end = (half_cnt == HALF_W'(SCK_HALF - 1));

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      half_cnt <= '0;
      sck      <= 1'b0;
      bit_idx  <= '0;
    end else if (half_end) begin
      half_cnt <= '0;
      sck      <= ~sck;
      if (sck) bit_idx <= (bit_idx == BIT_W'(NBITS - 1)) ? '0 : bit_idx + 1'b1;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

  assign rise = en && !sck && half_end;
  assign fall = en &&  sck && half_end;

endmodule

// File: rtl/ltc2308_ctrl.sv
// LTC2308 controller: CONVST pulse, conversion wait, then a 12-bit SPI read
// that shifts the next config word out on SDI while the result comes in on SDO.
module ltc2308_ctrl
  import ltc2308_pkg::*;
#(
  parameter int CONVST_CYC = 2,
  parameter int CONV_CYC   = 80,
  parameter int SCK_HALF   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CFG_W-1:0]  cfg,
  output logic              busy,
  output logic              data_valid,
  output logic [DATA_W-1:0] data,
  output logic [CFG_W-1:0]  data_cfg,
  output logic              adc_convst,
  output logic              adc_sck,
  output logic              adc_sdi,
  input  logic              adc_sdo
);

  localparam int CNT_MAX = (CONVST_CYC > CONV_CYC) ? CONVST_CYC : CONV_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CFG_W-1:0]  cfg_q;
  logic [CFG_W-1:0]  sdi_sr;
  logic [DATA_W-1:0] sdo_sr;
  logic              sck_en, sck_rise, sck_fall, last_fall;
  logic [BIT_W-1:0]  bit_idx;

  ltc2308_sck_gen #(.SCK_HALF(SCK_HALF)) u_sck_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (sck_en),
    .sck     (adc_sck),
    .rise    (sck_rise),
    .fall    (sck_fall),
    .bit_idx (bit_idx)
  );

  assign last_fall = sck_fall && (bit_idx == BIT_W'(NBITS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    data_valid = 1'b0;
    adc_convst = 1'b0;
    sck_en     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = CONVST;
      end
      CONVST: begin
        adc_convst = 1'b1;
        if (cnt == CNT_W'(CONVST_CYC - 1)) state_next = WAIT_CONV;
      end
      WAIT_CONV: begin
        if (cnt == CNT_W'(CONV_CYC - 1)) state_next = SHIFT;
      end
      SHIFT: begin
        sck_en = 1'b1;
        if (last_fall) state_next = DONE;
      end
      DONE: begin
        data_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // SDI is loaded as SHIFT is entered and advanced on the same edge SCK falls,
  // so it is always stable across each rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      cfg_q    <= '0;
      sdi_sr   <= '0;
      sdo_sr   <= '0;
      data     <= '0;
      data_cfg <= '0;
    end else begin
      cnt <= ((state_next == state) && (state == CONVST || state == WAIT_CONV))
             ? cnt + 1'b1 : '0;
      if (state == IDLE && start) cfg_q <= cfg;
      if (state != SHIFT)  sdi_sr <= (state_next == SHIFT) ? cfg_q : '0;
      else if (sck_fall)   sdi_sr <= {sdi_sr[CFG_W-2:0], 1'b0};
      if (sck_rise) sdo_sr <= {sdo_sr[DATA_W-2:0], adc_sdo};
      if (state_next == DONE) begin
        data     <= sdo_sr;
        data_cfg <= cfg_q;
      end
    end
  end

  assign adc_sdi = sdi_sr[CFG_W-1];

endmodule

// File: tb/tb_ltc2308_ctrl.sv
// Directed bench for ltc2308_ctrl with a behavioural LTC2308 serial model.
module tb_ltc2308_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [5:0]  cfg;
  logic        busy, data_valid;
  logic [11:0] data;
  logic [5:0]  data_cfg;
  logic        adc_convst, adc_sck, adc_sdi, adc_sdo;

  ltc2308_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg        (cfg),
    .busy       (busy),
    .data_valid (data_valid),
    .data       (data),
    .data_cfg   (data_cfg),
    .adc_convst (adc_convst),
    .adc_sck    (adc_sck),
    .adc_sdi    (adc_sdi),
    .adc_sdo    (adc_sdo)
  );

  always #5 clk = ~clk;

  // ADC model: result word loaded at CONVST rise, next bit presented on each SCK fall.
  logic [11:0] mdl_word;
  logic [11:0] mdl_sr;
  always @(posedge adc_convst or negedge adc_sck) begin
    if (adc_convst) mdl_sr <= mdl_word;
    else            mdl_sr <= {mdl_sr[10:0], 1'b0};
  end
  assign adc_sdo = mdl_sr[11];

  // Monitor, sampled on the falling clk edge.
  int          cyc = 0;
  int          n_acc = 0, n_dv = 0, n_lo = 0, n_convst = 0, n_rise = 0, n_glitch = 0;
  int          acc_log [16];
  int          dv_log  [16];
  int          lo_at_dv[16];
  logic [11:0] dv_data [16];
  logic [5:0]  dv_cfg  [16];
  logic [11:0] sdi_cap = '0;
  logic        prev_sck = 1'b0, prev_sdi = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && start && !busy && n_acc < 16) begin
      acc_log[n_acc] = cyc;
      n_acc++;
    end
    if (data_valid && n_dv < 16) begin
      dv_log[n_dv]   = cyc;
      dv_data[n_dv]  = data;
      dv_cfg[n_dv]   = data_cfg;
      lo_at_dv[n_dv] = n_lo;
      n_dv++;
    end
    if (!busy) n_lo++;
    if (adc_convst) n_convst++;
    if (adc_sck && !prev_sck) begin
      n_rise++;
      sdi_cap = {sdi_cap[10:0], adc_sdi};
    end
    if (adc_sck && prev_sck && (adc_sdi != prev_sdi)) n_glitch++;
    prev_sck = adc_sck;
    prev_sdi = adc_sdi;
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"},     32'(busy),       32'd0);
    check({tag, " dv"},       32'(data_valid), 32'd0);
    check({tag, " data"},     32'(data),       32'd0);
    check({tag, " data_cfg"}, 32'(data_cfg),   32'd0);
    check({tag, " convst"},   32'(adc_convst), 32'd0);
    check({tag, " sck"},      32'(adc_sck),    32'd0);
    check({tag, " sdi"},      32'(adc_sdi),    32'd0);
  endtask

  int a0, d0, c0, r0;

  initial begin
    rst = 1'b1; start = 1'b0; cfg = '0; mdl_word = '0;
    cycles(3);
    check_idle_outputs("reset");
    rst = 1'b0;
    cycles(3);

    // Single read, with ignored start pulses mid-conversion and in the data_valid cycle.
    a0 = n_acc; d0 = n_dv; c0 = n_convst; r0 = n_rise;
    mdl_word = 12'hA5C; cfg = 6'b100010; start = 1'b1;
    cycles(1);
    start = 1'b0; cfg = 6'b011111;
    cycles(9);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(120);
    check("a dv cycle", 32'(data_valid), 32'd1);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(20);
    check("a accepts",   32'(n_acc - a0), 32'd1);
    check("a dv count",  32'(n_dv - d0),  32'd1);
    check("a latency",   32'(dv_log[d0] - acc_log[a0]), 32'd131);
    check("a dv data",   32'(dv_data[d0]), 32'hA5C);
    check("a dv cfg",    32'(dv_cfg[d0]),  32'b100010);
    check("a data hold", 32'(data),        32'hA5C);
    check("a convst hi", 32'(n_convst - c0), 32'd2);
    check("a sck rises", 32'(n_rise - r0),   32'd12);
    check("a sdi bits",  32'(sdi_cap),       32'b1000_1000_0000);
    check("a busy end",  32'(busy),          32'd0);

    // start held high: back-to-back reads with one idle cycle between them.
    a0 = n_acc; d0 = n_dv;
    mdl_word = 12'h3C7; cfg = 6'b110101; start = 1'b1;
    cycles(400);
    start = 1'b0;
    cycles(200);
    check("b accepts",  32'(n_acc - a0), 32'd4);
    check("b dv count", 32'(n_dv - d0),  32'd4);
    check("b dv1 cyc",  32'(dv_log[d0]     - acc_log[a0]), 32'd131);
    check("b dv2 cyc",  32'(dv_log[d0 + 1] - acc_log[a0]), 32'd263);
    check("b idle gap", 32'(lo_at_dv[d0 + 1] - lo_at_dv[d0]), 32'd1);
    check("b data",     32'(dv_data[d0 + 1]), 32'h3C7);
    check("b cfg",      32'(dv_cfg[d0 + 1]),  32'b110101);

    // Reset during the fifth SCK pulse aborts the read.
    a0 = n_acc; d0 = n_dv; r0 = n_rise;
    mdl_word = 12'hFFF; cfg = 6'b101010; start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(100);
    check("c sck high", 32'(adc_sck), 32'd1);
    rst = 1'b1;
    cycles(1);
    check_idle_outputs("c abort");
    rst = 1'b0;
    cycles(150);
    check("c no dv",    32'(n_dv - d0),   32'd0);
    check("c rises",    32'(n_rise - r0), 32'd5);

    a0 = n_acc; d0 = n_dv;
    mdl_word = 12'h001; cfg = 6'b110000; start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(140);
    check("c2 dv count", 32'(n_dv - d0), 32'd1);
    check("c2 latency",  32'(dv_log[d0] - acc_log[a0]), 32'd131);
    check("c2 data",     32'(dv_data[d0]), 32'h001);
    check("c2 cfg",      32'(dv_cfg[d0]),  32'b110000);
    check("sdi stable while sck high", 32'(n_glitch), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ltc2308_ctrl.md
LTC2308_CTRL -- requirements
Module: ltc2308_ctrl

Interface
REQ-001 Parameter CONVST_CYC, default 2: clk cycles adc_convst is held high per conversion; legal range 1 or more.
REQ-002 Parameter CONV_CYC, default 80: clk cycles adc_convst is held low before the first SCK, covering tCONV max; legal range 1 or more.
REQ-003 Parameter SCK_HALF, default 2: clk cycles per SCK half-period; legal range 1 or more.
REQ-004 clk  in  1  sole clock; all logic is on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request one conversion; sampled only in IDLE.
REQ-007 cfg  in  6  LTC2308 config word {S/D, O/S, S1, S0, UNI, SLP}; latched when start is accepted.
REQ-008 busy  out  1  high from the cycle after start is accepted through the data_valid cycle, inclusive.
REQ-009 data_valid  out  1  one-cycle pulse; data and data_cfg are valid in that cycle.
REQ-010 data  out  12  conversion result, MSB first off SDO; holds its value until the next data_valid.
REQ-011 data_cfg  out  6  cfg word that was shifted out during this read; it configures the next conversion.
REQ-012 adc_convst  out  1  conversion start to the ADC.
REQ-013 adc_sck  out  1  serial clock to the ADC; idles low.
REQ-014 adc_sdi  out  1  config bits to the ADC.
REQ-015 adc_sdo  in  1  result bits from the ADC.

Function
REQ-016 States are IDLE, CONVST, WAIT_CONV, SHIFT and DONE.
REQ-017 IDLE with start=1 latches cfg and moves to CONVST the next cycle; start=0 stays in IDLE.
REQ-018 CONVST drives adc_convst=1 for exactly CONVST_CYC cycles, then moves to WAIT_CONV.
REQ-019 WAIT_CONV drives adc_convst=0 and adc_sck=0 for exactly CONV_CYC cycles, then moves to SHIFT.
REQ-020 SHIFT generates exactly 12 SCK pulses; each pulse is SCK_HALF cycles low followed by SCK_HALF cycles high, so SHIFT lasts 24*SCK_HALF cycles.
REQ-021 adc_sdi carries cfg[5-k] during pulse k (k=0..5) and 0 during pulses 6..11; adc_sdi changes only while adc_sck is low.
REQ-022 adc_sdo is sampled in the clk cycle in which adc_sck goes 0 to 1 and shifted into the LSB; the bit sampled on pulse 0 becomes data[11].
REQ-023 After the last high phase the FSM enters DONE: adc_sck=0, data, data_cfg and data_valid=1 are updated, and the FSM returns to IDLE the following cycle.
REQ-024 Latency from the start-accept cycle to the data_valid cycle is 1+CONVST_CYC+CONV_CYC+24*SCK_HALF cycles (131 with defaults).
REQ-025 start asserted while busy=1, including in the data_valid cycle, is ignored and not queued; changes on cfg while busy=1 have no effect.
REQ-026 A held-high start is accepted in the first IDLE cycle after DONE, giving back-to-back conversions.
REQ-027 adc_sdi=0 whenever the FSM is not in SHIFT.

Reset
REQ-028 While rst=1: state=IDLE; adc_convst, adc_sck, adc_sdi, busy and data_valid are 0; data=0; data_cfg=0; all counters are 0.
REQ-029 rst asserted in any state aborts the transaction within one cycle with no further SCK edges and no data_valid; a partial result is discarded.

Structure
REQ-030 Package ltc2308_pkg holds the state enum, CFG_W=6, DATA_W=12 and NBITS=12.
REQ-031 One sub-module, ltc2308_sck_gen, takes an enable and SCK_HALF and produces adc_sck plus single-cycle rise/fall strobes and a bit index of 0..11.

Verification
REQ-032 Bench uses defaults and the ADC behavioral model; each scenario checks the response stated.
REQ-033 start with cfg=6'b100010 and the model returning 12'hA5C -> data=12'hA5C, data_cfg=6'b100010, data_valid 131 cycles after start.
REQ-034 Capture adc_sdi on SCK rising edges -> 1,0,0,0,1,0,0,0,0,0,0,0; adc_convst high exactly 2 cycles; 12 SCK rises.
REQ-035 start pulsed again at cycles 10 and 131 after the first accept -> both ignored, exactly one data_valid.
REQ-036 start held high for 400 cycles -> data_valid at cycles 131 and 263, busy low exactly one cycle between them.
REQ-037 rst asserted during the 5th SCK pulse -> all outputs 0 next cycle, no data_valid; the next start yields a correct 12'h001 from the model.
